// File: rtl/serial_adder_unit_if.sv
// rtl/serial_adder_unit_if.sv - operand/result handshake bundle for the bit-serial adder
interface serial_adder_unit_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_adder_unit.sv
// rtl/serial_adder_unit.sv - bit-serial WIDTH-bit adder around a single full-adder cell
module serial_adder_unit #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_adder_unit_if.slave io
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic             cout_r;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last_bit;
   logic             fa_s;
   logic             fa_c;

   // The one full-adder cell, fed from the operand LSBs and the carry register
   assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
   assign fa_c     = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
   assign last_bit = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      accept       = 1'b0;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      io.busy      = 1'b0;
      unique case (state)
         IDLE: begin
            io.in_ready = 1'b1;
            if (io.in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            io.busy = 1'b1;
            if (last_bit) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            io.out_valid = 1'b1;
            if (io.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr   <= io.a;
         b_sr   <= io.b;
         sum_sr <= '0;
         carry  <= io.cin;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else if (state == RUN) begin
         // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
         carry  <= fa_c;
         cnt    <= cnt + 1'b1;
         if (last_bit) begin
            cout_r <= fa_c;
         end
      end
   end

   assign io.sum  = sum_sr;
   assign io.cout = cout_r;

endmodule

// File: tb/tb_serial_adder_unit.sv
// tb/tb_serial_adder_unit.sv - directed and back-to-back checks of serial_adder_unit at WIDTH 8, 1 and 13
module tb_serial_adder_unit;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   serial_adder_unit_if #(.WIDTH(8))  u8  ();
   serial_adder_unit_if #(.WIDTH(1))  u1  ();
   serial_adder_unit_if #(.WIDTH(13)) u13 ();

   serial_adder_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .io(u8.slave));
   serial_adder_unit #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .io(u1.slave));
   serial_adder_unit #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .io(u13.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 transaction; stall cycles of backpressure are applied once OUT_VALID is seen
   task automatic xact8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [8:0] exp, input int stall);
      int n;
      n = 0;
      while (!u8.in_ready && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_in_ready"}, 32'(u8.in_ready), 32'd1);
      u8.a        = a;
      u8.b        = b;
      u8.cin      = c;
      u8.in_valid = 1'b1;
      tick();
      u8.in_valid = 1'b0;
      chk({tag, "_busy"}, 32'({u8.busy, u8.in_ready, u8.out_valid}), 32'b100);
      n = 0;
      while (!u8.out_valid && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd8);
      chk({tag, "_result"}, 32'({u8.cout, u8.sum}), 32'(exp));
      for (int i = 0; i < stall; i++) begin
         u8.a        = ~u8.a;
         u8.b        = u8.b + 8'h33;
         u8.cin      = ~u8.cin;
         u8.in_valid = ~u8.in_valid;
         tick();
         chk({tag, "_stall_result"}, 32'({u8.cout, u8.sum}), 32'(exp));
         chk({tag, "_stall_flags"}, 32'({u8.out_valid, u8.in_ready, u8.busy}), 32'b100);
      end
      u8.in_valid  = 1'b0;
      u8.out_ready = 1'b1;
      tick();
      u8.out_ready = 1'b0;
      chk({tag, "_release"}, 32'({u8.out_valid, u8.in_ready, u8.busy}), 32'b010);
      chk({tag, "_retained"}, 32'({u8.cout, u8.sum}), 32'(exp));
   endtask

   initial begin
      logic [1:0] fa_tab [8];
      int         q[$];
      int         sent;
      int         got;
      int         cyc;
      int         n;
      logic [7:0]  ra8, rb8;
      logic [12:0] ra13, rb13;
      logic        rc;

      n_cmp = 0;
      n_bad = 0;
      fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      {u8.in_valid, u8.a, u8.b, u8.cin, u8.out_ready}      = '0;
      {u1.in_valid, u1.a, u1.b, u1.cin, u1.out_ready}      = '0;
      {u13.in_valid, u13.a, u13.b, u13.cin, u13.out_ready} = '0;

      rst_n = 1'b0;
      tick();
      tick();
      chk("reset_flags", 32'({u8.in_ready, u8.out_valid, u8.busy}), 32'b100);
      chk("reset_result", 32'({u8.cout, u8.sum}), 32'd0);
      rst_n = 1'b1;
      tick();

      xact8("zero",  8'h00, 8'h00, 1'b0, 9'h000, 0);
      xact8("ripple", 8'hFF, 8'h01, 1'b0, 9'h100, 0);
      xact8("a5_5a", 8'hA5, 8'h5A, 1'b1, 9'h100, 0);
      xact8("3c_42", 8'h3C, 8'h42, 1'b0, 9'h07E, 0);
      xact8("bp",    8'h3C, 8'h42, 1'b1, 9'h07F, 5);

      // Abort after four processing edges, then confirm a clean restart
      u8.a        = 8'hFF;
      u8.b        = 8'hFF;
      u8.cin      = 1'b0;
      u8.in_valid = 1'b1;
      tick();
      u8.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("midrun_busy", 32'(u8.busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrun_flags", 32'({u8.in_ready, u8.out_valid, u8.busy}), 32'b100);
      chk("midrun_result", 32'({u8.cout, u8.sum}), 32'd0);
      xact8("after_rst", 8'h01, 8'h01, 1'b0, 9'h002, 0);

      // WIDTH=1 full-adder truth table
      u1.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         u1.a        = 1'(i >> 2);
         u1.b        = 1'(i >> 1);
         u1.cin      = 1'(i);
         u1.in_valid = 1'b1;
         tick();
         u1.in_valid = 1'b0;
         chk("w1_busy", 32'(u1.busy), 32'd1);
         tick();
         chk("w1_valid", 32'(u1.out_valid), 32'd1);
         chk("w1_result", 32'({u1.cout, u1.sum}), 32'(fa_tab[i]));
         tick();
      end
      u1.out_ready = 1'b0;

      // Back-to-back traffic at WIDTH=8
      q.delete();
      sent = 0;
      got  = 0;
      cyc  = 0;
      u8.out_ready = 1'b1;
      while (got < 1000 && cyc < 20000) begin
         u8.in_valid = 1'b0;
         if (u8.in_ready && sent < 1000) begin
            ra8  = 8'($urandom);
            rb8  = 8'($urandom);
            rc   = 1'($urandom);
            u8.a = ra8;
            u8.b = rb8;
            u8.cin = rc;
            u8.in_valid = 1'b1;
            q.push_back(int'(ra8) + int'(rb8) + int'(rc));
            sent++;
         end
         if (u8.out_valid) begin
            if (q.size() == 0) begin
               chk("rnd8_extra", 32'd1, 32'd0);
            end else begin
               n = q.pop_front();
               chk("rnd8", 32'({u8.cout, u8.sum}), 32'(n));
            end
            got++;
         end
         tick();
         cyc++;
      end
      u8.in_valid  = 1'b0;
      u8.out_ready = 1'b0;
      chk("rnd8_count", 32'(got), 32'd1000);
      chk("rnd8_left", 32'(q.size()), 32'd0);

      // Back-to-back traffic at WIDTH=13
      q.delete();
      sent = 0;
      got  = 0;
      cyc  = 0;
      u13.out_ready = 1'b1;
      while (got < 1000 && cyc < 25000) begin
         u13.in_valid = 1'b0;
         if (u13.in_ready && sent < 1000) begin
            ra13 = 13'($urandom_range(0, 8191));
            rb13 = 13'($urandom_range(0, 8191));
            rc   = 1'($urandom);
            u13.a = ra13;
            u13.b = rb13;
            u13.cin = rc;
            u13.in_valid = 1'b1;
            q.push_back(int'(ra13) + int'(rb13) + int'(rc));
            sent++;
         end
         if (u13.out_valid) begin
            if (q.size() == 0) begin
               chk("rnd13_extra", 32'd1, 32'd0);
            end else begin
               n = q.pop_front();
               chk("rnd13", 32'({u13.cout, u13.sum}), 32'(n));
            end
            got++;
         end
         tick();
         cyc++;
      end
      u13.in_valid  = 1'b0;
      u13.out_ready = 1'b0;
      chk("rnd13_count", 32'(got), 32'd1000);
      chk("rnd13_left", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
